// File: rtl/pwm_fade_sequencer_if.sv
// Handshake bundle between the board start/stop controls, the PWM generator
// and the fade sequencer: controls and period strobe in, duty and status out.
interface pwm_fade_sequencer_if;
    logic       start;
    logic       stop;
    logic       period_end;
    logic [7:0] duty_cycle;
    logic       busy;
    logic       done;

    modport master (output start, stop, period_end, input duty_cycle, busy, done);
    modport slave  (input start, stop, period_end, output duty_cycle, busy, done);
endinterface

// File: rtl/pwm_fade_sequencer.sv
// Breathing-profile sequencer for an 8-bit PWM duty input; steps land only on PWM period boundaries.
// Define PWM_FADE_LOOP_EN to repeat the profile until stop; otherwise it runs once.
module pwm_fade_sequencer #(
    parameter int unsigned TICK_DIV   = 270000,
    parameter int unsigned STEP       = 1,
    parameter int unsigned HOLD_TICKS = 50,
    parameter int unsigned DUTY_MAX   = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    pwm_fade_sequencer_if.slave   bus
);
    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [8:0]    STEP9     = 9'(STEP);
    localparam logic [7:0]    DMAX      = 8'(DUTY_MAX);

    typedef enum logic [2:0] {IDLE, RAMP_UP, HOLD_HIGH, RAMP_DOWN, HOLD_LOW} state_t;

    state_t         state, nxt;
    logic [TW-1:0]  tick_cnt;
    logic [HW-1:0]  hold_cnt;
    logic           pending;
    logic           stop_latched;
    logic [7:0]     duty;
    logic           done_r;

    logic           busy_o, is_ramp, is_hold;
    logic           tick, apply, hold_done;
    logic [8:0]     up_sum;
    logic [7:0]     up_val, dn_val;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= nxt;
    end

    // Output / state-decode process
    always_comb begin
        busy_o  = (state != IDLE);
        is_ramp = (state == RAMP_UP) || (state == RAMP_DOWN);
        is_hold = (state == HOLD_HIGH) || (state == HOLD_LOW);
    end

    assign tick = busy_o && (tick_cnt == TICK_LAST);
    // A stop in RAMP_UP freezes duty, so it also suppresses a coincident step.
    assign apply = is_ramp && (tick || pending) && bus.period_end
                   && !(bus.stop && (state == RAMP_UP));
    assign hold_done = is_hold && tick && (hold_cnt == HOLD_LAST);

    assign up_sum = {1'b0, duty} + STEP9;
    assign up_val = (up_sum > {1'b0, DMAX}) ? DMAX : up_sum[7:0];
    assign dn_val = ({1'b0, duty} > STEP9) ? (duty - STEP9[7:0]) : 8'd0;

    // Next-state process
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      if (bus.start && !bus.stop) nxt = RAMP_UP;
            RAMP_UP: begin
                if (bus.stop)                      nxt = RAMP_DOWN;
                else if (apply && up_val == DMAX)  nxt = HOLD_HIGH;
            end
            HOLD_HIGH: if (bus.stop || hold_done)  nxt = RAMP_DOWN;
            RAMP_DOWN: begin
                if (apply && dn_val == 8'd0)
                    nxt = (bus.stop || stop_latched) ? IDLE : HOLD_LOW;
            end
            HOLD_LOW: begin
                if (bus.stop)       nxt = IDLE;
`ifdef PWM_FADE_LOOP_EN
                else if (hold_done) nxt = RAMP_UP;
`else
                else if (hold_done) nxt = IDLE;
`endif
            end
            default:                nxt = IDLE;
        endcase
    end

    // Counters, step bookkeeping and duty register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tick_cnt     <= '0;
            hold_cnt     <= '0;
            pending      <= 1'b0;
            stop_latched <= 1'b0;
            duty         <= 8'd0;
            done_r       <= 1'b0;
        end else begin
            if (state == IDLE || nxt == IDLE || tick) tick_cnt <= '0;
            else                                     tick_cnt <= tick_cnt + 1'b1;

            if (nxt != state)         hold_cnt <= '0;
            else if (is_hold && tick) hold_cnt <= hold_cnt + 1'b1;

            // Ticks collapse into one outstanding step until a period boundary takes it.
            if (nxt != state || !is_ramp || apply) pending <= 1'b0;
            else if (tick)                         pending <= 1'b1;

            if (nxt == IDLE)          stop_latched <= 1'b0;
            else if (busy_o && bus.stop) stop_latched <= 1'b1;

            if (busy_o && nxt == IDLE) duty <= 8'd0;
            else if (apply)            duty <= (state == RAMP_UP) ? up_val : dn_val;

            done_r <= busy_o && (nxt == IDLE);
        end
    end

    assign bus.duty_cycle = duty;
    assign bus.busy       = busy_o;
    assign bus.done       = done_r;
endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Directed bench for pwm_fade_sequencer with TICK_DIV=4, STEP=64, HOLD_TICKS=2, DUTY_MAX=255.
module tb_pwm_fade_sequencer;
    localparam int TICK_DIV = 4, STEP = 64, HOLD_TICKS = 2, DUTY_MAX = 255;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pwm_fade_sequencer_if bus();

    pwm_fade_sequencer #(.TICK_DIV(TICK_DIV), .STEP(STEP), .HOLD_TICKS(HOLD_TICKS),
                         .DUTY_MAX(DUTY_MAX))
        dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        bus.start = 1'b0; bus.stop = 1'b0; bus.period_end = 1'b0;
        rstn = 1'b0;
        cyc(2);
        rstn = 1'b1;
        cyc(1);
    endtask

    // Leaves time just after the edge that sampled start (k = 0).
    task automatic pulse_start();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
    endtask

    // Hand-derived one-shot duty profile, k = edges after start was sampled.
    function automatic int oneshot_duty(input int k);
        if (k < 4)  return 0;
        if (k < 8)  return 64;
        if (k < 12) return 128;
        if (k < 16) return 192;
        if (k < 28) return 255;
        if (k < 32) return 191;
        if (k < 36) return 127;
        if (k < 40) return 63;
        return 0;
    endfunction

    task automatic test_reset();
        bus.start = 1'b0; bus.stop = 1'b0; bus.period_end = 1'b1;
        #2;
        checks++;
        if (bus.duty_cycle !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold duty=%0d busy=%b done=%b want 0/0/0",
                     bus.duty_cycle, bus.busy, bus.done);
        end
        cyc(2);
        rstn = 1'b1;
        cyc(3);
        checks++;
        if (bus.duty_cycle !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release duty=%0d busy=%b done=%b want 0/0/0",
                     bus.duty_cycle, bus.busy, bus.done);
        end
    endtask

`ifndef PWM_FADE_LOOP_EN
    task automatic test_oneshot();
        do_reset();
        bus.period_end = 1'b1;
        pulse_start();
        for (int k = 0; k <= 50; k++) begin
            if (k > 0) cyc(1);
            checks++;
            if (bus.duty_cycle !== 8'(oneshot_duty(k))) begin
                errors++;
                $display("FAIL oneshot_duty k=%0d got %0d want %0d", k, bus.duty_cycle, oneshot_duty(k));
            end
            checks++;
            if (bus.busy !== (k <= 47) || bus.done !== (k == 48)) begin
                errors++;
                $display("FAIL oneshot_status k=%0d busy=%b done=%b want %b/%b",
                         k, bus.busy, bus.done, (k <= 47), (k == 48));
            end
        end
    endtask

    task automatic test_stop_hold_low();
        do_reset();
        bus.period_end = 1'b1;
        pulse_start();
        for (int k = 1; k <= 45; k++) begin
            cyc(1);
            bus.stop = (k == 41);
            if (k >= 36) begin
                checks++;
                if (bus.duty_cycle !== 8'(oneshot_duty(k)) || bus.busy !== (k <= 41) ||
                    bus.done !== (k == 42)) begin
                    errors++;
                    $display("FAIL stop_hold_low k=%0d duty=%0d busy=%b done=%b want %0d/%b/%b",
                             k, bus.duty_cycle, bus.busy, bus.done, oneshot_duty(k), (k <= 41), (k == 42));
                end
            end
        end
        bus.stop = 1'b0;
    endtask
`else
    task automatic test_loop();
        int ed;
        do_reset();
        bus.period_end = 1'b1;
        pulse_start();
        for (int k = 1; k <= 66; k++) begin
            cyc(1);
            bus.stop = (k == 56);
            if (k < 40)      ed = oneshot_duty(k);
            else if (k < 52) ed = 0;
            else if (k < 56) ed = 64;
            else if (k < 60) ed = 128;
            else if (k < 64) ed = 64;
            else             ed = 0;
            checks++;
            if (bus.duty_cycle !== 8'(ed) || bus.busy !== (k <= 63) || bus.done !== (k == 64)) begin
                errors++;
                $display("FAIL loop k=%0d duty=%0d busy=%b done=%b want %0d/%b/%b",
                         k, bus.duty_cycle, bus.busy, bus.done, ed, (k <= 63), (k == 64));
            end
        end
        bus.stop = 1'b0;
    endtask
`endif

    task automatic test_stop_ramp_up();
        int ed;
        do_reset();
        bus.period_end = 1'b1;
        pulse_start();
        for (int k = 1; k <= 18; k++) begin
            cyc(1);
            bus.stop = (k == 8);
            ed = (k < 4) ? 0 : (k < 8) ? 64 : (k < 12) ? 128 : (k < 16) ? 64 : 0;
            checks++;
            if (bus.duty_cycle !== 8'(ed) || bus.busy !== (k <= 15) || bus.done !== (k == 16)) begin
                errors++;
                $display("FAIL stop_ramp_up k=%0d duty=%0d busy=%b done=%b want %0d/%b/%b",
                         k, bus.duty_cycle, bus.busy, bus.done, ed, (k <= 15), (k == 16));
            end
        end
        bus.stop = 1'b0;
    endtask

    task automatic test_stop_hold_high();
        int ed;
        do_reset();
        bus.period_end = 1'b1;
        pulse_start();
        for (int k = 1; k <= 34; k++) begin
            cyc(1);
            bus.stop = (k == 17);
            ed = (k < 16) ? oneshot_duty(k) : (k < 20) ? 255 : (k < 24) ? 191 :
                 (k < 28) ? 127 : (k < 32) ? 63 : 0;
            checks++;
            if (bus.duty_cycle !== 8'(ed) || bus.busy !== (k <= 31) || bus.done !== (k == 32)) begin
                errors++;
                $display("FAIL stop_hold_high k=%0d duty=%0d busy=%b done=%b want %0d/%b/%b",
                         k, bus.duty_cycle, bus.busy, bus.done, ed, (k <= 31), (k == 32));
            end
        end
        bus.stop = 1'b0;
    endtask

    task automatic test_sparse_period();
        int ed;
        do_reset();
        bus.period_end = 1'b0;
        pulse_start();
        for (int k = 1; k <= 61; k++) begin
            cyc(1);
            bus.period_end = ((k % 10) == 9);
            ed = (k < 10) ? 0 : (k < 20) ? 64 : (k < 30) ? 128 : (k < 40) ? 192 :
                 (k < 60) ? 255 : 191;
            checks++;
            if (bus.duty_cycle !== 8'(ed) || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL sparse k=%0d duty=%0d busy=%b want %0d/1", k, bus.duty_cycle, bus.busy, ed);
            end
        end
        bus.period_end = 1'b0;
    endtask

    task automatic test_start_while_busy();
        do_reset();
        bus.period_end = 1'b1;
        pulse_start();
        for (int k = 1; k <= 17; k++) begin
            cyc(1);
            bus.start = (k == 8);
            checks++;
            if (bus.duty_cycle !== 8'(oneshot_duty(k)) || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL start_busy k=%0d duty=%0d busy=%b want %0d/1",
                         k, bus.duty_cycle, bus.busy, oneshot_duty(k));
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_start_stop_idle();
        do_reset();
        bus.period_end = 1'b1;
        bus.start = 1'b1; bus.stop = 1'b1;
        cyc(1);
        bus.start = 1'b0; bus.stop = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (bus.duty_cycle !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL start_stop_idle k=%0d duty=%0d busy=%b done=%b want 0/0/0",
                         k, bus.duty_cycle, bus.busy, bus.done);
            end
            cyc(1);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.period_end = 1'b1;
        pulse_start();
        cyc(33);
        checks++;
        if (bus.duty_cycle !== 8'd127) begin
            errors++;
            $display("FAIL mid_pre duty=%0d want 127", bus.duty_cycle);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (bus.duty_cycle !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL mid_async duty=%0d busy=%b done=%b want 0/0/0",
                     bus.duty_cycle, bus.busy, bus.done);
        end
        cyc(3);
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            checks++;
            if (bus.duty_cycle !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL mid_idle k=%0d duty=%0d busy=%b done=%b want 0/0/0",
                         k, bus.duty_cycle, bus.busy, bus.done);
            end
        end
        pulse_start();
        cyc(4);
        checks++;
        if (bus.duty_cycle !== 8'd64 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_restart duty=%0d busy=%b want 64/1", bus.duty_cycle, bus.busy);
        end
    endtask

    initial begin
        test_reset();
`ifdef PWM_FADE_LOOP_EN
        test_loop();
`else
        test_oneshot();
        test_stop_hold_low();
`endif
        test_stop_ramp_up();
        test_stop_hold_high();
        test_sparse_period();
        test_start_while_busy();
        test_start_stop_idle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
